// File: rtl/avalon_pkg.sv
// avalon_pkg: arbiter FSM state type and default Avalon bus widths/watchdog limit
package avalon_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int AVL_ADDR_WIDTH = 32;
  localparam int AVL_DATA_WIDTH = 32;
  localparam int AVL_WAIT_TIMEOUT = 255;
endpackage

// File: rtl/avl_arb_pick.sv
// avl_arb_pick: one-hot winner from req[1:0] {m1,m0}; ARB_ROUND_ROBIN_EN picks the master not in last_grant on a tie, else m0 wins
module avl_arb_pick
  import avalon_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] win
);
`ifdef ARB_ROUND_ROBIN_EN
  always_comb win = &req ? (last_grant[0] ? 2'b10 : 2'b01) : req;
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
  always_comb win = req[0] ? 2'b01 : req;
`endif
endmodule

// File: rtl/avalon_arbiter.sv
// avalon_arbiter: two-master Avalon-MM arbiter (m0/m1 -> avl slave) with registered grant, waitrequest handshake, timeout watchdog; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module avalon_arbiter
  import avalon_pkg::*;
#(
  parameter int ADDR_WIDTH   = AVL_ADDR_WIDTH,
  parameter int DATA_WIDTH   = AVL_DATA_WIDTH,
  parameter int WAIT_TIMEOUT = AVL_WAIT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic                    m0_read,
  input  logic                    m0_write,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic                    m1_read,
  input  logic                    m1_write,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_waitrequest,
  output logic [ADDR_WIDTH-1:0]   avl_address,
  output logic [DATA_WIDTH/8-1:0] avl_byteenable,
  output logic [DATA_WIDTH-1:0]   avl_writedata,
  output logic                    avl_read,
  output logic                    avl_write,
  input  logic [DATA_WIDTH-1:0]   avl_readdata,
  input  logic                    avl_waitrequest,
  output logic [1:0]              grant,
  output logic                    timeout_err
);
  localparam int CW = WAIT_TIMEOUT > 0 ? $clog2(WAIT_TIMEOUT + 1) : 1;
  arb_state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] req, win, last_grant;
  logic busy, sel, abort, done;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  avl_arb_pick u_pick (.req(req), .last_grant(last_grant), .win(win));
  always_comb begin
    busy = state == ARB_BUSY;
    sel = grant[1];
    avl_address = busy ? (sel ? m1_address : m0_address) : '0;
    avl_byteenable = busy ? (sel ? m1_byteenable : m0_byteenable) : '0;
    avl_writedata = busy ? (sel ? m1_writedata : m0_writedata) : '0;
    avl_write = busy & (sel ? m1_write : m0_write);
    avl_read = busy & (sel ? m1_read & ~m1_write : m0_read & ~m0_write);
    abort = busy & avl_waitrequest & (WAIT_TIMEOUT != 0) & (cnt == CW'(WAIT_TIMEOUT - 1));
    done = busy & (~avl_waitrequest | ~(avl_read | avl_write) | abort);
    timeout_err = abort;
    m0_waitrequest = grant[0] ? avl_waitrequest & ~abort : 1'b1;
    m1_waitrequest = grant[1] ? avl_waitrequest & ~abort : 1'b1;
    m0_readdata = abort ? '0 : avl_readdata;
    m1_readdata = abort ? '0 : avl_readdata;
  end
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 2'b10;
    else if (!busy && |win) last_grant <= win;
  end
`else
  assign last_grant = 2'b10;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      cnt <= '0;
    end else if (!busy) begin
      state <= |win ? ARB_BUSY : ARB_IDLE;
      grant <= win;
      cnt <= '0;
    end else begin
      state <= done ? ARB_IDLE : ARB_BUSY;
      grant <= done ? 2'b00 : grant;
      cnt <= avl_waitrequest ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_avalon_arbiter.sv
// tb_avalon_arbiter: table-driven and directed checks of avalon_arbiter (WAIT_TIMEOUT=8, fixed priority)
module tb_avalon_arbiter;
  logic clk, rst;
  logic [31:0] m0_address, m0_writedata, m0_readdata, m1_address, m1_writedata, m1_readdata;
  logic [3:0] m0_byteenable, m1_byteenable, avl_byteenable;
  logic m0_read, m0_write, m0_waitrequest, m1_read, m1_write, m1_waitrequest;
  logic [31:0] avl_address, avl_writedata, avl_readdata;
  logic avl_read, avl_write, avl_waitrequest, timeout_err;
  logic [1:0] grant;
  int checks = 0;
  int errors = 0;
  avalon_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_write(m0_write), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .avl_address(avl_address), .avl_byteenable(avl_byteenable), .avl_writedata(avl_writedata),
    .avl_read(avl_read), .avl_write(avl_write), .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
    .grant(grant), .timeout_err(timeout_err)
  );
  typedef struct {
    logic m0r, m0w; logic [31:0] m0a;
    logic m1r, m1w; logic [31:0] m1a; logic [3:0] m1be; logic [31:0] m1wd;
    logic aw; logic [31:0] ard;
    logic [1:0] g; logic er, ew; logic [31:0] ea; logic [3:0] ebe; logic [31:0] ewd;
    logic w0, w1; logic [31:0] rd0;
  } vec_t;
  vec_t vecs[16];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    vecs[0]  = '{0,0,32'h0,        0,0,32'h0,  4'h0,32'h0,        0,32'h0,        2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'h0};
    vecs[1]  = '{1,0,32'hBFC00000, 0,0,32'h0,  4'h0,32'h0,        1,32'h0,        2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'h0};
    vecs[2]  = '{1,0,32'hBFC00000, 0,0,32'h0,  4'h0,32'h0,        1,32'h0,        2'b01,1,0,32'hBFC00000, 4'hF,32'h11111111, 1,1,32'h0};
    vecs[3]  = vecs[2];
    vecs[4]  = '{1,0,32'hBFC00000, 0,0,32'h0,  4'h0,32'h0,        0,32'h3C011234, 2'b01,1,0,32'hBFC00000, 4'hF,32'h11111111, 0,1,32'h3C011234};
    vecs[5]  = vecs[0];
    vecs[6]  = '{1,0,32'h0,        0,1,32'h100,4'h1,32'hDDCCBBAA, 0,32'h0,        2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'h0};
    vecs[7]  = '{1,0,32'h0,        0,1,32'h100,4'h1,32'hDDCCBBAA, 0,32'h0,        2'b01,1,0,32'h0,        4'hF,32'h11111111, 0,1,32'h0};
    vecs[8]  = '{0,0,32'h0,        0,1,32'h100,4'h1,32'hDDCCBBAA, 0,32'h0,        2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'h0};
    vecs[9]  = '{0,0,32'h0,        0,1,32'h100,4'h1,32'hDDCCBBAA, 0,32'h0,        2'b10,0,1,32'h100,      4'h1,32'hDDCCBBAA, 1,0,32'h0};
    vecs[10] = vecs[0];
    vecs[11] = '{1,1,32'h20,       0,0,32'h0,  4'h0,32'h0,        0,32'h0,        2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'h0};
    vecs[12] = '{1,1,32'h20,       0,0,32'h0,  4'h0,32'h0,        0,32'h0,        2'b01,0,1,32'h20,       4'hF,32'h11111111, 0,1,32'h0};
    vecs[13] = '{0,0,32'h0,        1,0,32'h40, 4'hC,32'h0,        0,32'hCAFEF00D, 2'b00,0,0,32'h0,        4'h0,32'h0,        1,1,32'hCAFEF00D};
    vecs[14] = '{0,0,32'h0,        1,0,32'h40, 4'hC,32'h0,        0,32'hCAFEF00D, 2'b10,1,0,32'h40,       4'hC,32'h0,        1,0,32'hCAFEF00D};
    vecs[15] = vecs[0];
    m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 32'h11111111; m0_read = 0; m0_write = 0;
    m1_address = 0; m1_byteenable = 0; m1_writedata = 0; m1_read = 0; m1_write = 0;
    avl_readdata = 0; avl_waitrequest = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_avl_read", avl_read, 1'b0);
    chk("rst_avl_write", avl_write, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      m0_read = vecs[i].m0r; m0_write = vecs[i].m0w; m0_address = vecs[i].m0a;
      m1_read = vecs[i].m1r; m1_write = vecs[i].m1w; m1_address = vecs[i].m1a;
      m1_byteenable = vecs[i].m1be; m1_writedata = vecs[i].m1wd;
      avl_waitrequest = vecs[i].aw; avl_readdata = vecs[i].ard;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].g);
      chk($sformatf("v%0d_avl_read", i), avl_read, vecs[i].er);
      chk($sformatf("v%0d_avl_write", i), avl_write, vecs[i].ew);
      chk($sformatf("v%0d_avl_address", i), avl_address, vecs[i].ea);
      chk($sformatf("v%0d_avl_be", i), avl_byteenable, vecs[i].ebe);
      chk($sformatf("v%0d_avl_wdata", i), avl_writedata, vecs[i].ewd);
      chk($sformatf("v%0d_m0_wait", i), m0_waitrequest, vecs[i].w0);
      chk($sformatf("v%0d_m1_wait", i), m1_waitrequest, vecs[i].w1);
      chk($sformatf("v%0d_m0_rdata", i), m0_readdata, vecs[i].rd0);
      chk($sformatf("v%0d_timeout", i), timeout_err, 1'b0);
    end
    @(posedge clk);
    #1;
    m1_read = 1; m1_address = 32'h80; avl_waitrequest = 1; avl_readdata = 32'hFFFFFFFF;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to%0d_grant", k), grant, 2'b10);
      chk($sformatf("to%0d_timeout", k), timeout_err, k == 8);
      chk($sformatf("to%0d_m1_wait", k), m1_waitrequest, k != 8);
      chk($sformatf("to%0d_m1_rdata", k), m1_readdata, k == 8 ? 32'h0 : 32'hFFFFFFFF);
      @(posedge clk);
    end
    #1;
    m1_read = 0; avl_waitrequest = 0; avl_readdata = 0;
    @(negedge clk);
    chk("to_after_grant", grant, 2'b00);
    chk("to_after_timeout", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    m0_write = 1; m0_address = 32'h200; avl_waitrequest = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rb_avl_write", avl_write, 1'b1);
    chk("rb_grant", grant, 2'b01);
    #2 rst = 1;
    #1;
    chk("rb_rst_avl_write", avl_write, 1'b0);
    chk("rb_rst_grant", grant, 2'b00);
    chk("rb_rst_m0_wait", m0_waitrequest, 1'b1);
    #1;
    rst = 0; avl_waitrequest = 0;
    @(negedge clk);
    chk("rb_regrant", grant, 2'b01);
    chk("rb_regrant_write", avl_write, 1'b1);
    chk("rb_regrant_m0_wait", m0_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    m0_write = 0;
    @(negedge clk);
    chk("rb_idle_grant", grant, 2'b00);
    @(posedge clk);
    #1;
    m0_read = 1; m0_address = 32'h300; avl_waitrequest = 1;
    @(posedge clk);
    @(negedge clk);
    chk("dr_avl_read", avl_read, 1'b1);
    m0_read = 0;
    #1;
    chk("dr_avl_read_drop", avl_read, 1'b0);
    chk("dr_timeout", timeout_err, 1'b0);
    @(negedge clk);
    chk("dr_idle_grant", grant, 2'b00);
    chk("dr_idle_timeout", timeout_err, 1'b0);
    chk("dr_idle_m0_wait", m0_waitrequest, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
